ovs_sampling_timer: RTL and testbench

Parametrised bit-centre timer for the transceiver receive path. It keeps the existing half-bit preload and periodic reload scheme and adds four things: a fractional bit period, an oversampling window of OVS sub-samples around each bit centre, majority voting, and explicit idle/abort control. It sits between the rx synchroniser and the receive shift/FSM logic and delivers one voted bit per strobe.

---
 rtl/ovs_sampling_timer.sv | 208 ++++++++++++++++++++
 tb/tb_ovs_sampling_timer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovs_sampling_timer.sv
// Bit-centre timer for the receive path: fractional bit period, an OVS-wide
// sub-sample window around each centre, majority vote, and idle/abort control.
// o_sample strobes once per bit with the voted value on o_bit_val/o_noisy.
module ovs_sampling_timer #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 4,
   parameter int OVS    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic [CNT_W+FRAC_W-1:0] i_bit_time,
   input  logic [7:0]              i_gap,
   input  logic                    i_rx,
   output logic                    o_sample,
   output logic                    o_bit_val,
   output logic                    o_noisy,
   output logic                    o_active,
   output logic                    o_cfg_err
);

   localparam int H     = (OVS - 1) / 2;
   localparam int FW    = (FRAC_W > 0) ? FRAC_W : 1;
   localparam int VW    = $clog2(OVS + 1);
   localparam int HG_W  = 11;
   localparam int CMP_W = ((CNT_W > HG_W) ? CNT_W : HG_W) + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]      r_state;
   logic [CNT_W-1:0] r_i;
   logic [FW-1:0]   r_f;
   logic [7:0]      r_gap;
   logic [HG_W-1:0] r_hg;
   logic [CNT_W-1:0] r_cnt;
   logic [FW-1:0]   r_acc;
   logic            r_busy;
   logic [VW-1:0]   r_idx;
   logic [7:0]      r_gcnt;
   logic [VW-1:0]   r_ones;
   logic            r_sample;
   logic            r_bit_val;
   logic            r_noisy;
   logic            r_cfg_err;

   logic [CNT_W-1:0] w_i_raw;
   logic [CNT_W-1:0] w_i;
   logic [CNT_W-1:0] w_p;
   logic [FW-1:0]   w_f;
   logic [HG_W-1:0] w_hg_raw;
   logic            w_err;
   logic [7:0]      w_gap_eff;
   logic [HG_W-1:0] w_hg_eff;
   logic [FW:0]     w_acc_sum;
   logic [CNT_W-1:0] w_reload;
   logic            w_centre;
   logic            w_run;
   logic            w_hit;
   logic            w_open;
   logic            w_step;
   logic            w_take;
   logic            w_all_at_once;
   logic            w_last;
   logic [VW-1:0]   w_ones_nxt;

   // Configuration decode from the live inputs; only used on the start cycle.
   assign w_i_raw  = i_bit_time[FRAC_W +: CNT_W];
   assign w_i      = (w_i_raw == '0) ? CNT_W'(1) : w_i_raw;
   assign w_p      = (w_i - CNT_W'(1)) >> 1;
   assign w_hg_raw = HG_W'(H) * HG_W'(i_gap);
   // A half-window wider than the preload would open before the first centre
   // could be reached, so such a gap collapses the window onto the centre.
   assign w_err     = CMP_W'(w_hg_raw) > CMP_W'(w_p);
   assign w_gap_eff = w_err ? 8'd0 : i_gap;
   assign w_hg_eff  = w_err ? '0 : w_hg_raw;

   generate
      if (FRAC_W > 0) begin : g_frac
         assign w_f = i_bit_time[FRAC_W-1:0];
      end else begin : g_nofrac
         assign w_f = '0;
      end
   endgenerate

   // Fractional period: the carry out of the accumulator stretches one bit by a cycle.
   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_f};
   assign w_reload  = r_i - CNT_W'(1) + CNT_W'(w_acc_sum[FW]);
   assign w_centre  = (r_cnt == '0);
   // start and stop both abort whatever the engine was about to do this cycle.
   assign w_run     = (r_state == S_RUN) && !i_start && !i_stop;

   assign w_hit         = CMP_W'(r_cnt) == CMP_W'(r_hg);
   assign w_open        = w_run && !r_busy && w_hit;
   assign w_step        = w_run && r_busy && (r_gcnt == 8'd0);
   assign w_take        = w_open || w_step;
   assign w_all_at_once = (r_gap == 8'd0) || (OVS == 1);

   // Vote accumulation for the sub-sample taken this cycle, if any.
   always_comb begin
      w_ones_nxt = r_ones;
      w_last     = 1'b0;
      if (w_open) begin
         if (w_all_at_once) begin
            w_ones_nxt = i_rx ? VW'(OVS) : '0;
            w_last     = 1'b1;
         end else begin
            w_ones_nxt = VW'(i_rx);
         end
      end else if (w_step) begin
         w_ones_nxt = r_ones + VW'(i_rx);
         w_last     = (r_idx == VW'(OVS - 1));
      end
   end

   // Control FSM and configuration latch; start has priority over stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_i       <= '0;
         r_f       <= '0;
         r_gap     <= '0;
         r_hg      <= '0;
         r_cfg_err <= 1'b0;
      end else if (i_start) begin
         r_state   <= S_RUN;
         r_i       <= w_i;
         r_f       <= w_f;
         r_gap     <= w_gap_eff;
         r_hg      <= w_hg_eff;
         r_cfg_err <= w_err;
      end else if (i_stop) begin
         r_state   <= S_IDLE;
      end
   end

   // Main down-counter: half-bit preload on start, period reload at each centre.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (i_start) begin
         r_cnt <= w_p;
         r_acc <= '0;
      end else if (i_stop) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (r_state == S_RUN) begin
         if (w_centre) begin
            r_cnt <= w_reload;
            r_acc <= w_acc_sum[FW-1:0];
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   // Sub-sample window: opens at cnt == h*gap, then one sample every gap cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_idx  <= '0;
         r_gcnt <= '0;
         r_ones <= '0;
      end else if (i_start || i_stop) begin
         r_busy <= 1'b0;
         r_idx  <= '0;
         r_gcnt <= '0;
         r_ones <= '0;
      end else if (w_take) begin
         if (w_last) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
            r_ones <= '0;
         end else begin
            r_busy <= 1'b1;
            r_ones <= w_ones_nxt;
            r_idx  <= w_open ? VW'(1) : r_idx + VW'(1);
            r_gcnt <= r_gap - 8'd1;
         end
      end else if (r_busy) begin
         r_gcnt <= r_gcnt - 8'd1;
      end
   end

   // Strobe and vote result one cycle after the last sub-sample; values hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample  <= 1'b0;
         r_bit_val <= 1'b0;
         r_noisy   <= 1'b0;
      end else begin
         r_sample <= w_take && w_last;
         if (w_take && w_last) begin
            r_bit_val <= (w_ones_nxt > VW'(H));
            r_noisy   <= (w_ones_nxt != '0) && (w_ones_nxt != VW'(OVS));
         end
      end
   end

   assign o_sample  = r_sample;
   assign o_bit_val = r_bit_val;
   assign o_noisy   = r_noisy;
   assign o_active  = (r_state == S_RUN);
   assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_ovs_sampling_timer.sv
// Directed bench for ovs_sampling_timer (CNT_W=32, FRAC_W=4, OVS=3).
// Per-cycle input tables drive the DUT; a timeline model derives expected
// strobe cycles and votes from bit period, preload and window geometry.
module tb_ovs_sampling_timer;

   localparam int CNT_W  = 32;
   localparam int FRAC_W = 4;
   localparam int OVS    = 3;
   localparam int H      = (OVS - 1) / 2;
   localparam int NMAX   = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start, i_stop, i_rx;
   logic [35:0] i_bit_time;
   logic [7:0]  i_gap;
   logic        o_sample, o_bit_val, o_noisy, o_active, o_cfg_err;

   int tests = 0;
   int fails = 0;

   bit          st_v[NMAX];
   bit          sp_v[NMAX];
   bit          rx_v[NMAX];
   logic [35:0] bt_v[NMAX];
   logic [7:0]  gp_v[NMAX];

   bit         exp_s[NMAX];
   bit         exp_act[NMAX];
   bit         exp_err[NMAX];
   logic [1:0] exp_q[$];

   bit cap_bv[NMAX];
   bit cap_nz[NMAX];
   bit cap_act[NMAX];
   bit cap_err[NMAX];
   int cap_q[$];
   int eq[$];

   int cur_cyc = 0;
   bit chk_en  = 1'b0;
   bit m_bv    = 1'b0;
   bit m_nz    = 1'b0;

   ovs_sampling_timer #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (i_start),
      .i_stop    (i_stop),
      .i_bit_time(i_bit_time),
      .i_gap     (i_gap),
      .i_rx      (i_rx),
      .o_sample  (o_sample),
      .o_bit_val (o_bit_val),
      .o_noisy   (o_noisy),
      .o_active  (o_active),
      .o_cfg_err (o_cfg_err)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, k, got, exp);
      end
   endtask

   task automatic chk_caps(input string name, input int e[$]);
      int got;
      chk({name, "_count"}, -1, 64'(cap_q.size()), 64'(e.size()));
      for (int i = 0; i < e.size(); i++) begin
         got = (i < cap_q.size()) ? cap_q[i] : -1;
         chk({name, "_cycle"}, i, 64'(got), 64'(e[i]));
      end
   endtask

   // Timeline model: for every start, walk the bit centres and place windows.
   task automatic build_model(input int n);
      longint bi, f, p, g, hg, c, acc, s;
      int     e, ones;
      bit     err;
      exp_q.delete();
      for (int k = 0; k < NMAX; k++) begin
         exp_s[k] = 0; exp_act[k] = 0; exp_err[k] = 0;
      end
      for (int t = 0; t < n; t++) begin
         if (st_v[t]) begin
            e = n;
            for (int k = t + 1; k < n; k++) begin
               if (st_v[k] || sp_v[k]) begin
                  e = k;
                  break;
               end
            end
            bi = longint'(bt_v[t] >> 4);
            f  = longint'(bt_v[t] & 36'hf);
            if (bi == 0) bi = 1;
            p   = (bi - 1) / 2;
            g   = longint'(gp_v[t]);
            err = (H * g) > p;
            if (err) g = 0;
            hg  = H * g;
            for (int k = t + 1; k < n; k++) exp_err[k] = err;
            for (int k = t + 1; k <= e && k < n; k++) exp_act[k] = 1;
            c   = t + 1 + p;
            acc = 0;
            s   = c + hg + 1;
            while (s <= e && s < n) begin
               ones = 0;
               for (int j = 0; j < OVS; j++) ones += int'(rx_v[int'(c - hg + j * g)]);
               exp_s[int'(s)] = 1;
               exp_q.push_back({(ones > H), (ones != 0 && ones != OVS)});
               acc = acc + f;
               c   = c + bi + ((acc >= 16) ? 1 : 0);
               acc = acc % 16;
               s   = c + hg + 1;
            end
         end
      end
   endtask

   // Per-cycle comparison against the model, half a cycle after each input change.
   always @(negedge clk) begin
      int k;
      logic [1:0] v;
      if (chk_en) begin
         k = cur_cyc;
         if (exp_s[k]) begin
            v = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
            m_bv = v[1];
            m_nz = v[0];
         end
         chk("sample", k, 64'(o_sample), 64'(exp_s[k]));
         chk("bit_val", k, 64'(o_bit_val), 64'(m_bv));
         chk("noisy", k, 64'(o_noisy), 64'(m_nz));
         chk("active", k, 64'(o_active), 64'(exp_act[k]));
         chk("cfg_err", k, 64'(o_cfg_err), 64'(exp_err[k]));
         cap_bv[k]  = o_bit_val;
         cap_nz[k]  = o_noisy;
         cap_act[k] = o_active;
         cap_err[k] = o_cfg_err;
         if (o_sample === 1'b1) cap_q.push_back(k);
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_sample"}, -1, 64'(o_sample), 64'd0);
      chk({tag, "_bit_val"}, -1, 64'(o_bit_val), 64'd0);
      chk({tag, "_noisy"}, -1, 64'(o_noisy), 64'd0);
      chk({tag, "_active"}, -1, 64'(o_active), 64'd0);
      chk({tag, "_cfg_err"}, -1, 64'(o_cfg_err), 64'd0);
   endtask

   task automatic do_reset();
      chk_en     = 1'b0;
      rst_n      = 1'b0;
      i_start    = 1'b0;
      i_stop     = 1'b0;
      i_rx       = 1'b0;
      i_bit_time = '0;
      i_gap      = '0;
      @(posedge clk); #1;
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_bv  = 1'b0;
      m_nz  = 1'b0;
      cap_q.delete();
      for (int k = 0; k < NMAX; k++) begin
         cap_bv[k] = 0; cap_nz[k] = 0; cap_act[k] = 0; cap_err[k] = 0;
      end
   endtask

   task automatic prep(input bit rx_const, input bit rx_val);
      for (int k = 0; k < NMAX; k++) begin
         st_v[k] = 0;
         sp_v[k] = 0;
         rx_v[k] = rx_const ? rx_val : 1'($urandom_range(0, 1));
         bt_v[k] = {4'($urandom), 32'($urandom)};
         gp_v[k] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic start_at(input int k, input logic [35:0] bt, input logic [7:0] g);
      st_v[k] = 1;
      bt_v[k] = bt;
      gp_v[k] = g;
   endtask

   // Driver: one table row per cycle, applied just after the rising edge.
   task automatic run_scn(input int n);
      chk_en = 1'b1;
      for (int k = 0; k < n; k++) begin
         cur_cyc    = k;
         i_start    = st_v[k];
         i_stop     = sp_v[k];
         i_rx       = rx_v[k];
         i_bit_time = bt_v[k];
         i_gap      = gp_v[k];
         @(posedge clk); #1;
      end
      chk_en = 1'b0;
   endtask

   task automatic go(input int n);
      build_model(n);
      do_reset();
      run_scn(n);
   endtask

   initial begin
      rst_n = 1'b0;

      // 16.0 period, gap 2, steady high line
      prep(1, 1);
      start_at(0, 36'd256, 8'd2);
      go(40);
      eq = '{11, 27};
      chk_caps("s1", eq);
      chk("s1_bv11", 11, 64'(cap_bv[11]), 64'd1);
      chk("s1_nz11", 11, 64'(cap_nz[11]), 64'd0);
      chk("s1_err", 11, 64'(cap_err[11]), 64'd0);

      // Disagreeing sub-samples: 1,0,1 then 0,1,0
      prep(0, 0);
      start_at(0, 36'd256, 8'd2);
      rx_v[6] = 1;  rx_v[8] = 0;  rx_v[10] = 1;
      rx_v[22] = 0; rx_v[24] = 1; rx_v[26] = 0;
      go(30);
      chk("s2_bv11", 11, 64'(cap_bv[11]), 64'd1);
      chk("s2_nz11", 11, 64'(cap_nz[11]), 64'd1);
      chk("s2_bv27", 27, 64'(cap_bv[27]), 64'd0);
      chk("s2_nz27", 27, 64'(cap_nz[27]), 64'd1);

      // Fractional period 16.5, gap 0
      prep(0, 0);
      start_at(0, 36'd264, 8'd0);
      go(80);
      eq = '{9, 25, 42, 58, 75};
      chk_caps("s3", eq);

      // Illegal gap then legal restart
      prep(0, 0);
      start_at(0, 36'd128, 8'd5);
      start_at(20, 36'd128, 8'd1);
      go(40);
      eq = '{5, 13, 26, 34};
      chk_caps("s4", eq);
      chk("s4_err_on", 10, 64'(cap_err[10]), 64'd1);
      chk("s4_err_off", 30, 64'(cap_err[30]), 64'd0);

      // Restart inside the first window
      prep(1, 1);
      start_at(0, 36'd256, 8'd2);
      start_at(9, 36'd256, 8'd2);
      go(40);
      eq = '{20, 36};
      chk_caps("s5", eq);

      // Stop during the window
      prep(1, 1);
      start_at(0, 36'd256, 8'd2);
      sp_v[7] = 1;
      go(40);
      eq.delete();
      chk_caps("s6", eq);
      chk("s6_act7", 7, 64'(cap_act[7]), 64'd1);
      chk("s6_act8", 8, 64'(cap_act[8]), 64'd0);

      // Integer part zero behaves as one: a strobe every cycle
      prep(0, 0);
      start_at(0, 36'd0, 8'd1);
      go(12);
      eq = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
      chk_caps("s8", eq);
      chk("s8_err", 5, 64'(cap_err[5]), 64'd1);

      // Start and stop together inside the window: start wins
      prep(1, 1);
      start_at(0, 36'd256, 8'd2);
      start_at(9, 36'd256, 8'd2);
      sp_v[9] = 1;
      go(40);
      eq = '{20, 36};
      chk_caps("s9", eq);

      // Asynchronous reset while the strobe is high
      prep(1, 1);
      start_at(0, 36'd256, 8'd2);
      go(11);
      chk("s7_pre_sample", 11, 64'(o_sample), 64'd1);
      rst_n = 1'b0;
      #1;
      check_zero("s7_async");
      @(posedge clk); #1;
      check_zero("s7_held");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
